// File: rtl/pong_top.sv
// Still-screen Pong for 640x480@60 VGA: pixel-enable divider, sync generator and
// a fixed wall / paddle / ball colour map driven from the current scan position.
module pong_top #(
  parameter int HD = 640,
  parameter int HF = 16,
  parameter int HR = 96,
  parameter int HB = 48,
  parameter int VD = 480,
  parameter int VF = 10,
  parameter int VR = 2,
  parameter int VB = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb
);

  localparam logic [9:0] H_MAX        = 10'(HD + HF + HR + HB - 1);
  localparam logic [9:0] V_MAX        = 10'(VD + VF + VR + VB - 1);
  localparam logic [9:0] H_SYNC_START = 10'(HD + HF);
  localparam logic [9:0] H_SYNC_END   = 10'(HD + HF + HR - 1);
  localparam logic [9:0] V_SYNC_START = 10'(VD + VF);
  localparam logic [9:0] V_SYNC_END   = 10'(VD + VF + VR - 1);
  localparam logic [9:0] H_DISP       = 10'(HD);
  localparam logic [9:0] V_DISP       = 10'(VD);

  localparam logic [9:0] WALL_X_L   = 10'd32;
  localparam logic [9:0] WALL_X_R   = 10'd35;
  localparam logic [9:0] PADDLE_X_L = 10'd600;
  localparam logic [9:0] PADDLE_X_R = 10'd603;
  localparam logic [9:0] PADDLE_Y_T = 10'd204;
  localparam logic [9:0] PADDLE_Y_B = 10'd276;
  localparam logic [9:0] BALL_X_L   = 10'd580;
  localparam logic [9:0] BALL_X_R   = 10'd588;
  localparam logic [9:0] BALL_Y_T   = 10'd238;
  localparam logic [9:0] BALL_Y_B   = 10'd246;

  localparam logic [11:0] RGB_BLACK  = 12'h000;
  localparam logic [11:0] RGB_WALL   = 12'h060;
  localparam logic [11:0] RGB_PADDLE = 12'hFF0;
  localparam logic [11:0] RGB_BALL   = 12'hF0F;

  logic [1:0] tick_cnt_q, tick_cnt_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;

  logic       pixel_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       wall_on, paddle_on, ball_on;

  assign pixel_tick = (tick_cnt_q == 2'd3);
  assign pixel_x    = pixel_x_q;
  assign pixel_y    = pixel_y_q;

  // Counters advance from the named position nets so the scan position is the
  // single source for both the next-state logic and the colour map.
  always_comb begin
    tick_cnt_d = tick_cnt_q + 2'd1;
    pixel_x_d  = pixel_x;
    pixel_y_d  = pixel_y;
    if (pixel_tick) begin
      if (pixel_x == H_MAX) begin
        pixel_x_d = '0;
        pixel_y_d = (pixel_y == V_MAX) ? '0 : pixel_y + 10'd1;
      end else begin
        pixel_x_d = pixel_x + 10'd1;
      end
    end
  end

  always_comb begin
    hsync_d = !((pixel_x >= H_SYNC_START) && (pixel_x <= H_SYNC_END));
    vsync_d = !((pixel_y >= V_SYNC_START) && (pixel_y <= V_SYNC_END));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      pixel_x_q  <= '0;
      pixel_y_q  <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      pixel_x_q  <= pixel_x_d;
      pixel_y_q  <= pixel_y_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;

  assign video_on  = (pixel_x < H_DISP) && (pixel_y < V_DISP);
  assign wall_on   = (pixel_x >= WALL_X_L) && (pixel_x <= WALL_X_R);
  assign paddle_on = (pixel_x >= PADDLE_X_L) && (pixel_x <= PADDLE_X_R) &&
                     (pixel_y >= PADDLE_Y_T) && (pixel_y <= PADDLE_Y_B);
  assign ball_on   = (pixel_x >= BALL_X_L) && (pixel_x <= BALL_X_R) &&
                     (pixel_y >= BALL_Y_T) && (pixel_y <= BALL_Y_B);

  always_comb begin
    rgb = RGB_BLACK;
    if (!video_on)      rgb = RGB_BLACK;
    else if (wall_on)   rgb = RGB_WALL;
    else if (paddle_on) rgb = RGB_PADDLE;
    else if (ball_on)   rgb = RGB_BALL;
  end

endmodule

// File: tb/tb_pong_top.sv
// Scoreboard bench for pong_top: expected pixel colours are queued per scan position
// and compared as the raster reaches them; sync widths and counter wraps are measured.
module tb_pong_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync, vsync;
  logic [11:0] rgb;

  pong_top dut (
    .clk   (clk),
    .rst   (rst),
    .hsync (hsync),
    .vsync (vsync),
    .rgb   (rgb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    logic [11:0] rgb;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc   = 0;
  logic [9:0]  fx, fy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int x, input int y, input logic [11:0] c, input string tag);
    exp_t e;
    e.x = x; e.y = y; e.rgb = c; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("sb_drain", sb_q.size(), 0);
    sb_q.delete();
  endtask

  // Parks the raster on the pixel before (x,y) for one pixel-enable edge, so the
  // design itself steps onto (x,y) and the tick phase restarts cleanly.
  task automatic jump_to(input int x, input int y);
    int px, py, n;
    px = x - 1;
    py = y;
    if (x == 0) begin
      px = 799;
      py = (y == 0) ? 524 : y - 1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dut.pixel_tick && n < 16);
    check_eq("jump_tick", dut.pixel_tick, 1);
    fx = 10'(px);
    fy = 10'(py);
    force dut.pixel_x = fx;
    force dut.pixel_y = fy;
    @(posedge clk);
    #1;
    release dut.pixel_x;
    release dut.pixel_y;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && sb_q.size() > 0) begin
        if (int'(dut.pixel_x) == sb_q[0].x && int'(dut.pixel_y) == sb_q[0].y) begin
          mon_e = sb_q.pop_front();
          check_eq(mon_e.tag, {20'd0, rgb}, {20'd0, mon_e.rgb});
        end
      end
    end
  end

  initial begin
    int n;
    int unsigned t0;

    rst = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("rst_x", dut.pixel_x, 0);
    check_eq("rst_y", dut.pixel_y, 0);
    check_eq("rst_hsync", hsync, 1);
    check_eq("rst_vsync", vsync, 1);
    check_eq("rst_tick", dut.pixel_tick, 0);

    push(31, 0, 12'h000, "l0_x31");
    push(32, 0, 12'h060, "l0_x32");
    push(33, 0, 12'h060, "l0_x33");
    push(34, 0, 12'h060, "l0_x34");
    push(35, 0, 12'h060, "l0_x35");
    push(36, 0, 12'h000, "l0_x36");
    rst = 1'b0;

    n = 0;
    do begin @(negedge clk); n++; end while (!dut.pixel_tick && n < 10);
    check_eq("first_tick", n, 3);
    n = 0;
    do begin @(negedge clk); n++; end while (!dut.pixel_tick && n < 10);
    check_eq("tick_period", n, 4);
    check_eq("x_after_tick", dut.pixel_x, 1);
    wait_drain(400);

    jump_to(30, 479);
    push(32, 479, 12'h060, "wall_y479");
    wait_drain(40);
    jump_to(30, 480);
    push(32, 480, 12'h000, "wall_y480");
    wait_drain(40);

    jump_to(598, 204);
    push(600, 204, 12'hFF0, "pad_y204");
    wait_drain(40);
    jump_to(598, 276);
    push(600, 276, 12'hFF0, "pad_y276");
    wait_drain(40);
    jump_to(598, 203);
    push(600, 203, 12'h000, "pad_y203");
    wait_drain(40);
    jump_to(602, 240);
    push(603, 240, 12'hFF0, "pad_x603");
    push(604, 240, 12'h000, "pad_x604");
    wait_drain(40);

    jump_to(578, 238);
    push(579, 238, 12'h000, "ball_x579");
    push(580, 238, 12'hF0F, "ball_tl");
    wait_drain(40);
    jump_to(586, 246);
    push(588, 246, 12'hF0F, "ball_br");
    wait_drain(40);
    jump_to(587, 240);
    push(588, 240, 12'hF0F, "ball_x588");
    push(589, 240, 12'h000, "ball_x589");
    wait_drain(40);

    jump_to(638, 480);
    for (int x = 638; x < 800; x++) push(x, 480, 12'h000, "blank_x");
    wait_drain(800);
    n = 0;
    while (dut.pixel_x != 0 && n < 16) begin @(negedge clk); n++; end
    check_eq("xwrap_x", dut.pixel_x, 0);
    check_eq("xwrap_y", dut.pixel_y, 481);

    jump_to(798, 524);
    n = 0;
    while (dut.pixel_x != 0 && n < 16) begin @(negedge clk); n++; end
    check_eq("ywrap_x", dut.pixel_x, 0);
    check_eq("ywrap_y", dut.pixel_y, 0);
    push(31, 0, 12'h000, "ywrap_x31");
    push(32, 0, 12'h060, "ywrap_x32");
    wait_drain(200);

    jump_to(600, 10);
    n = 0;
    while (hsync !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
    t0 = cyc;
    check_eq("hs_start_x", dut.pixel_x, 656);
    n = 0;
    while (hsync === 1'b0 && n < 1000) begin n++; @(negedge clk); end
    check_eq("hs_width_clk", n, 384);
    n = 0;
    while (hsync !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
    check_eq("line_period_clk", cyc - t0, 3200);

    jump_to(790, 489);
    n = 0;
    while (vsync !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
    check_eq("vs_start_y", dut.pixel_y, 490);
    check_eq("vs_start_x", dut.pixel_x, 0);
    n = 0;
    while (vsync === 1'b0 && n < 8000) begin n++; @(negedge clk); end
    check_eq("vs_width_clk", n, 6400);
    check_eq("vs_end_y", dut.pixel_y, 492);

    jump_to(700, 300);
    repeat (3) @(negedge clk);
    check_eq("mid_hsync_low", hsync, 0);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_x", dut.pixel_x, 0);
    check_eq("mid_rst_y", dut.pixel_y, 0);
    check_eq("mid_rst_hsync", hsync, 1);
    check_eq("mid_rst_vsync", vsync, 1);
    repeat (3) @(negedge clk);
    push(31, 0, 12'h000, "mid_x31");
    push(32, 0, 12'h060, "mid_x32");
    push(35, 0, 12'h060, "mid_x35");
    push(36, 0, 12'h000, "mid_x36");
    rst = 1'b0;
    wait_drain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
